hist_bank: RTL and testbench
============================

# hist_bank

Parametrised histogram accumulator: accepts a stream of bin indices over a valid/ready handshake, keeps one counter per bin, and on request streams every bin's count out in index order with a last marker. It sits between the sample front end and the top-level I/O wrapper, replacing the fixed 8-bit histogramming block. It adds configurable bin count and counter width, a back-pressured dump, optional clear-on-read, out-of-range detection, and sticky overflow status.

## Interface
- NUM_BINS, 16, number of bins (2..256, any value)
- CNT_W, 8, counter width in bits (2..16)
- BIN_W, $clog2(NUM_BINS) (min 1), bin index width (derived, do not override)
- CLEAR_ON_DUMP, 0, 1 = each bin zeroed in the cycle its count is handshaken out
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample present
- in_ready  out  1  accepting samples (high only in ACCUM)
- in_bin  in  BIN_W  bin index of sample
- dump_req  in  1  single-cycle request to stream all bins
- clear_req  in  1  single-cycle request to zero all bins and status
- out_valid  out  1  out_bin/out_count valid
- out_ready  in  1  consumer accepts current bin
- out_bin  out  BIN_W  index of bin being output
- out_count  out  CNT_W  count of that bin
- out_last  out  1  high with out_valid on bin NUM_BINS-1
- busy  out  1  high in DUMP
- overflow  out  1  sticky: some counter hit its limit
- dropped  out  1  sticky: a sample with in_bin >= NUM_BINS was accepted

## Operation
- States: ACCUM, DUMP. Reset enters ACCUM, all counters 0, all outputs 0 except in_ready=1.
- ACCUM: in_ready=1; on in_valid, counter[in_bin] increments. If in_bin >= NUM_BINS, no counter changes and dropped sets.
- Counter at 2^CNT_W-1 receiving a sample: overflow sets; value per Configuration.
- dump_req in ACCUM → DUMP next cycle. A sample handshaken in the dump_req cycle is counted and included in the dump.
- DUMP: in_ready=0, busy=1, out_valid=1, out_bin starts at 0; out_count = counter[out_bin]; advance on out_valid&&out_ready. After the handshake with out_last=1 → ACCUM next cycle.
- CLEAR_ON_DUMP=1: counter[out_bin] is zeroed on its handshake; otherwise counters are untouched by dump.
- clear_req (any state): all counters, overflow, and dropped are zeroed next cycle; state → ACCUM; out_valid drops. It wins over dump_req and over a simultaneous sample.
- dump_req during DUMP is ignored. out_valid stays high and out_bin/out_count stay stable while out_ready=0.
- rst_n low mid-dump: immediate return to reset state; no partial output resumes.

## Timing
- Sample to counter update: 1 cycle (visible in a dump starting the next cycle).
- dump_req to first out_valid: 1 cycle.
- Full dump with out_ready held high: NUM_BINS cycles; in_ready returns 1 in the cycle after the last handshake.
- Throughput: 1 sample/cycle in ACCUM, 1 bin/cycle in DUMP.
- Status flags update 1 cycle after the causing handshake.

## Configuration
- HIST_SATURATE_EN defined: a counter at 2^CNT_W-1 stays at that value on further samples; overflow sets.
- HIST_SATURATE_EN undefined: the counter wraps to 0; overflow sets.

## Structure
- Package hist_pkg holds the state enum (ACCUM, DUMP) and a helper for the derived BIN_W.
- Sub-module hist_bin_cnt implements one counter: increment, clear, saturate/wrap, and overflow pulse. It is instantiated NUM_BINS times via generate. The top level holds the FSM, the dump index, the output mux, and the sticky flags.

## Test plan
- Defaults: 5 samples to bin 3 and 2 to bin 15, then dump_req with out_ready=1 → 16 beats; bin3=5, bin15=2, others 0; out_last only on bin 15; in_ready back 17 cycles after dump_req.
- Dump with out_ready toggling 1/0 → out_bin/out_count stable during stalls; every bin is emitted exactly once, in order.
- 300 samples to bin 7 (CNT_W=8) → count 255 with HIST_SATURATE_EN, 44 without; overflow=1 in both cases.
- NUM_BINS=10, sample in_bin=12 → no counter change; dropped=1; a subsequent clear_req → dropped=0.
- CLEAR_ON_DUMP=1: bin 2=4, dump, then dump again → second dump shows all zeros.
- rst_n asserted while out_bin=5 mid-dump, and clear_req coincident with dump_req → outputs at reset values / state ACCUM with all counters 0 and no DUMP entered.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared types and helpers for the hist_bank histogram accumulator.
package hist_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } hist_state_t;

  // Bin index width, never narrower than one bit.
  function automatic int hist_bin_w(input int num_bins);
    return (num_bins > 2) ? $clog2(num_bins) : 1;
  endfunction

endpackage

// File: rtl/hist_bin_cnt.sv
// One histogram bin counter with clear, increment and an overflow pulse.
// HIST_SATURATE_EN defined: the counter holds at its maximum; otherwise it wraps to zero.
module hist_bin_cnt import hist_pkg::*; #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
`ifdef HIST_SATURATE_EN
      if (!w_at_max) r_cnt <= r_cnt + 1'b1;
`else
      r_cnt <= r_cnt + 1'b1;
`endif
    end
  end

  // Clear takes precedence, so a sample lost to a clear never flags overflow.
  assign o_ovf = i_inc && !i_clr && w_at_max;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/hist_bank.sv
// Histogram accumulator: counts bin indices in ACCUM, streams all bins in DUMP.
// Counter limit behaviour selected by HIST_SATURATE_EN (see hist_bin_cnt).
module hist_bank import hist_pkg::*; #(
  parameter int NUM_BINS      = 16,
  parameter int CNT_W         = 8,
  parameter int BIN_W         = hist_bin_w(NUM_BINS),
  parameter bit CLEAR_ON_DUMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_bin,
  input  logic             dump_req,
  input  logic             clear_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_bin,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last,
  output logic             busy,
  output logic             overflow,
  output logic             dropped
);

  localparam logic [BIN_W:0]   NB       = (BIN_W+1)'(NUM_BINS);
  localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(NUM_BINS - 1);

  hist_state_t      r_state;
  hist_state_t      w_state_nxt;
  logic [BIN_W-1:0] r_idx;
  logic [BIN_W-1:0] w_idx_nxt;
  logic             r_overflow;
  logic             r_dropped;

  logic             w_accept;
  logic             w_in_range;
  logic             w_last;
  logic             w_out_hs;
  logic             w_any_ovf;
  logic [NUM_BINS-1:0] w_inc;
  logic [NUM_BINS-1:0] w_clr;
  logic [NUM_BINS-1:0] w_ovf;
  logic [CNT_W-1:0]    w_cnt [NUM_BINS];

  // clear_req discards any sample offered in the same cycle.
  assign w_accept   = in_valid && (r_state == ACCUM) && !clear_req;
  assign w_in_range = ({1'b0, in_bin} < NB);
  assign w_last     = (r_idx == LAST_IDX);
  assign w_out_hs   = (r_state == DUMP) && out_ready;
  assign w_any_ovf  = |w_ovf;

  for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
    assign w_inc[g] = w_accept && w_in_range && (in_bin == BIN_W'(g));
    assign w_clr[g] = clear_req ||
                      (CLEAR_ON_DUMP && w_out_hs && (r_idx == BIN_W'(g)));

    hist_bin_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc[g]),
      .i_clr (w_clr[g]),
      .o_cnt (w_cnt[g]),
      .o_ovf (w_ovf[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (clear_req) begin
      w_state_nxt = ACCUM;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (dump_req) begin
            w_state_nxt = DUMP;
            w_idx_nxt   = '0;
          end
        end
        DUMP: begin
          if (w_out_hs) begin
            if (w_last) begin
              w_state_nxt = ACCUM;
              w_idx_nxt   = '0;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ACCUM;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ACCUM;
      r_idx      <= '0;
      r_overflow <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (clear_req) begin
        r_overflow <= 1'b0;
        r_dropped  <= 1'b0;
      end else begin
        if (w_any_ovf)               r_overflow <= 1'b1;
        if (w_accept && !w_in_range) r_dropped  <= 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign busy      = (r_state == DUMP);
  assign out_valid = busy;
  assign out_bin   = r_idx;
  assign out_count = busy ? w_cnt[r_idx] : '0;
  assign out_last  = busy && w_last;
  assign overflow  = r_overflow;
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_hist_bank.sv
// Scoreboard bench for hist_bank: default instance plus a 10-bin clear-on-dump instance.
`timescale 1ns/1ps
module tb_hist_bank;

  typedef struct packed {
    logic [3:0] bin;
    logic [7:0] cnt;
    logic       last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_in_valid = 1'b0, a_dump_req = 1'b0, a_clear_req = 1'b0, a_out_ready = 1'b0;
  logic [3:0] a_in_bin = '0;
  logic       a_in_ready, a_out_valid, a_out_last, a_busy, a_overflow, a_dropped;
  logic [3:0] a_out_bin;
  logic [7:0] a_out_count;

  logic       b_in_valid = 1'b0, b_dump_req = 1'b0, b_clear_req = 1'b0, b_out_ready = 1'b0;
  logic [3:0] b_in_bin = '0;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy, b_overflow, b_dropped;
  logic [3:0] b_out_bin;
  logic [7:0] b_out_count;

  int errors = 0;
  int checks = 0;
  int unsigned ma [16];
  int unsigned mb [10];
  exp_t sbq [$];

  hist_bank u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bin(a_in_bin),
    .dump_req(a_dump_req), .clear_req(a_clear_req), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_bin(a_out_bin), .out_count(a_out_count), .out_last(a_out_last), .busy(a_busy),
    .overflow(a_overflow), .dropped(a_dropped)
  );

  hist_bank #(.NUM_BINS(10), .CNT_W(8), .CLEAR_ON_DUMP(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin),
    .dump_req(b_dump_req), .clear_req(b_clear_req), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_bin(b_out_bin), .out_count(b_out_count), .out_last(b_out_last), .busy(b_busy),
    .overflow(b_overflow), .dropped(b_dropped)
  );

  function automatic int unsigned inc_model(input int unsigned v);
`ifdef HIST_SATURATE_EN
    return (v == 255) ? 255 : v + 1;
`else
    return (v == 255) ? 0 : v + 1;
`endif
  endfunction

  task automatic send_a(input int bin, input int n);
    a_in_valid = 1'b1;
    a_in_bin   = 4'(bin);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ma[bin] = inc_model(ma[bin]);
    end
    a_in_valid = 1'b0;
  endtask

  task automatic clear_a();
    a_clear_req = 1'b1;
    @(posedge clk); #1;
    a_clear_req = 1'b0;
    foreach (ma[i]) ma[i] = 0;
    checks++;
    if (a_overflow !== 1'b0 || a_dropped !== 1'b0 || a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_state: ovf=%b drop=%b busy=%b out_valid=%b in_ready=%b, expected 0 0 0 0 1",
               a_overflow, a_dropped, a_busy, a_out_valid, a_in_ready);
    end
  endtask

  // Full dump of instance A; smp >= 0 offers a sample in the dump_req cycle.
  task automatic dump_a(input bit toggle, input int smp, output int cycles);
    exp_t e;
    logic [3:0] pb;
    logic [7:0] pc;
    bit stalled;
    stalled = 1'b0;
    pb = '0;
    pc = '0;
    if (smp >= 0) begin
      a_in_valid = 1'b1;
      a_in_bin   = 4'(smp);
      ma[smp]    = inc_model(ma[smp]);
    end
    for (int i = 0; i < 16; i++) begin
      e.bin  = 4'(i);
      e.cnt  = 8'(ma[i]);
      e.last = (i == 15);
      sbq.push_back(e);
    end
    a_dump_req = 1'b1;
    @(posedge clk); #1;
    a_dump_req = 1'b0;
    a_in_valid = 1'b1;
    a_in_bin   = 4'd4;
    cycles     = 1;
    while (sbq.size() > 0 && cycles < 100) begin
      a_out_ready = toggle ? cycles[0] : 1'b1;
      checks++;
      if (a_out_valid !== 1'b1 || a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL dump_status: out_valid=%b busy=%b in_ready=%b, expected 1 1 0", a_out_valid, a_busy, a_in_ready);
      end
      if (stalled) begin
        checks++;
        if (a_out_bin !== pb || a_out_count !== pc) begin
          errors++;
          $display("FAIL stall_hold: bin=%0d count=%0d, expected bin=%0d count=%0d", a_out_bin, a_out_count, pb, pc);
        end
      end
      if (a_out_ready) begin
        e = sbq.pop_front();
        checks++;
        if (a_out_bin !== e.bin || a_out_count !== e.cnt || a_out_last !== e.last) begin
          errors++;
          $display("FAIL dump_beat: bin=%0d count=%0d last=%b, expected bin=%0d count=%0d last=%b",
                   a_out_bin, a_out_count, a_out_last, e.bin, e.cnt, e.last);
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pb = a_out_bin;
        pc = a_out_count;
      end
      @(posedge clk); #1;
      cycles++;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    checks++;
    if (sbq.size() != 0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL dump_end: beats_left=%0d in_ready=%b busy=%b, expected 0 1 0", sbq.size(), a_in_ready, a_busy);
      sbq.delete();
    end
  endtask

  task automatic dump_b();
    exp_t e;
    int n;
    for (int i = 0; i < 10; i++) begin
      e.bin  = 4'(i);
      e.cnt  = 8'(mb[i]);
      e.last = (i == 9);
      sbq.push_back(e);
      mb[i] = 0;
    end
    b_dump_req = 1'b1;
    @(posedge clk); #1;
    b_dump_req  = 1'b0;
    b_out_ready = 1'b1;
    n = 0;
    while (sbq.size() > 0 && n < 50) begin
      e = sbq.pop_front();
      checks++;
      if (b_out_valid !== 1'b1 || b_out_bin !== e.bin || b_out_count !== e.cnt || b_out_last !== e.last) begin
        errors++;
        $display("FAIL b_dump_beat: valid=%b bin=%0d count=%0d last=%b, expected 1 bin=%0d count=%0d last=%b",
                 b_out_valid, b_out_bin, b_out_count, b_out_last, e.bin, e.cnt, e.last);
      end
      @(posedge clk); #1;
      n++;
    end
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({a_in_ready, a_out_valid, a_busy, a_out_last, a_overflow, a_dropped} !== 6'b100000 ||
        a_out_bin !== 4'd0 || a_out_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_a: flags=%b bin=%0d count=%0d, expected flags=100000 bin=0 count=0",
               {a_in_ready, a_out_valid, a_busy, a_out_last, a_overflow, a_dropped}, a_out_bin, a_out_count);
    end
    checks++;
    if ({b_in_ready, b_out_valid, b_busy, b_out_last, b_overflow, b_dropped} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_b: flags=%b, expected 100000", {b_in_ready, b_out_valid, b_busy, b_out_last, b_overflow, b_dropped});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b busy=%b, expected 1 0 0", a_in_ready, a_out_valid, a_busy);
    end
  endtask

  task automatic test_basic();
    int cyc;
    send_a(3, 5);
    send_a(15, 2);
    checks++;
    if (a_overflow !== 1'b0 || a_dropped !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_flags: ovf=%b drop=%b in_ready=%b, expected 0 0 1", a_overflow, a_dropped, a_in_ready);
    end
    dump_a(1'b0, -1, cyc);
    checks++;
    if (cyc != 17) begin
      errors++;
      $display("FAIL basic_latency: in_ready returned after %0d cycles, expected 17", cyc);
    end
  endtask

  task automatic test_stall();
    int cyc;
    dump_a(1'b1, -1, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    a_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_in_bin = 4'(i);
      @(posedge clk); #1;
      ma[i] = inc_model(ma[i]);
    end
    a_in_valid = 1'b0;
    dump_a(1'b0, 9, cyc);
    checks++;
    if (cyc != 17) begin
      errors++;
      $display("FAIL b2b_latency: in_ready returned after %0d cycles, expected 17", cyc);
    end
    dump_a(1'b0, -1, cyc);
  endtask

  task automatic test_saturate();
    int cyc;
    clear_a();
    a_in_valid = 1'b1;
    a_in_bin   = 4'd7;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      ma[7] = inc_model(ma[7]);
      if (i == 254) begin
        checks++;
        if (a_overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early: overflow=%b after 255 samples, expected 0", a_overflow);
        end
      end
      if (i == 255) begin
        checks++;
        if (a_overflow !== 1'b1) begin
          errors++;
          $display("FAIL ovf_set: overflow=%b after 256 samples, expected 1", a_overflow);
        end
      end
    end
    a_in_valid = 1'b0;
    dump_a(1'b0, -1, cyc);
    checks++;
    if (a_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b, expected 1", a_overflow);
    end
    clear_a();
  endtask

  task automatic test_dropped_clear_on_dump();
    b_in_valid = 1'b1;
    b_in_bin   = 4'd12;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    checks++;
    if (b_dropped !== 1'b1) begin
      errors++;
      $display("FAIL dropped_set: dropped=%b, expected 1", b_dropped);
    end
    b_in_valid = 1'b1;
    b_in_bin   = 4'd2;
    repeat (4) @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    mb[2] = 4;
    dump_b();
    dump_b();
    checks++;
    if (b_dropped !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL dropped_hold: dropped=%b in_ready=%b, expected 1 1", b_dropped, b_in_ready);
    end
    b_clear_req = 1'b1;
    @(posedge clk); #1;
    b_clear_req = 1'b0;
    checks++;
    if (b_dropped !== 1'b0) begin
      errors++;
      $display("FAIL dropped_clear: dropped=%b, expected 0", b_dropped);
    end
  endtask

  task automatic test_clear_vs_dump();
    int cyc;
    send_a(6, 3);
    a_dump_req  = 1'b1;
    a_clear_req = 1'b1;
    a_in_valid  = 1'b1;
    a_in_bin    = 4'd6;
    @(posedge clk); #1;
    a_dump_req  = 1'b0;
    a_clear_req = 1'b0;
    a_in_valid  = 1'b0;
    foreach (ma[i]) ma[i] = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL clear_wins_%0d: busy=%b out_valid=%b in_ready=%b, expected 0 0 1", k, a_busy, a_out_valid, a_in_ready);
      end
      @(posedge clk); #1;
    end
    dump_a(1'b0, -1, cyc);
    send_a(1, 2);
    a_dump_req = 1'b1;
    @(posedge clk); #1;
    a_dump_req  = 1'b0;
    a_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a_clear_req = 1'b1;
    @(posedge clk); #1;
    a_clear_req = 1'b0;
    a_out_ready = 1'b0;
    foreach (ma[i]) ma[i] = 0;
    checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_out_bin !== 4'd0) begin
      errors++;
      $display("FAIL clear_in_dump: out_valid=%b busy=%b in_ready=%b bin=%0d, expected 0 0 1 0",
               a_out_valid, a_busy, a_in_ready, a_out_bin);
    end
    dump_a(1'b0, -1, cyc);
  endtask

  task automatic test_reset_mid_dump();
    int cyc;
    int n;
    send_a(2, 3);
    a_dump_req = 1'b1;
    @(posedge clk); #1;
    a_dump_req  = 1'b0;
    a_out_ready = 1'b1;
    n = 0;
    while (a_out_bin !== 4'd5 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    a_out_ready = 1'b0;
    checks++;
    if (a_out_bin !== 4'd5 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_dump_reach: bin=%0d busy=%b, expected 5 1", a_out_bin, a_busy);
    end
    rst_n = 1'b0;
    #1;
    foreach (ma[i]) ma[i] = 0;
    foreach (mb[i]) mb[i] = 0;
    checks++;
    if ({a_in_ready, a_out_valid, a_busy, a_out_last, a_overflow, a_dropped} !== 6'b100000 ||
        a_out_bin !== 4'd0 || a_out_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_dump: flags=%b bin=%0d count=%0d, expected flags=100000 bin=0 count=0",
               {a_in_ready, a_out_valid, a_busy, a_out_last, a_overflow, a_dropped}, a_out_bin, a_out_count);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_resume: busy=%b out_valid=%b in_ready=%b, expected 0 0 1", a_busy, a_out_valid, a_in_ready);
    end
    dump_a(1'b0, -1, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_saturate();
    test_dropped_clear_on_dump();
    test_clear_vs_dump();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
